// File: rtl/ram_stream_reader.sv
// Streams a contiguous (wrapping) region of a 1-cycle-latency RAM out as valid/ready words.
// Optional macro RAM_READER_LAST_EN adds an out_last sideband marking the final word.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef RAM_READER_LAST_EN
  ,
  output logic                  out_last
`endif
);

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_done, w_done_nxt;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [ADDR_WIDTH-1:0] r_read_addr;
  logic                  r_vld_p0, r_vld_p1;
  logic [2:0]            r_count;
  logic [1:0]            r_wr_ptr, r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic [2:0] w_inflight;
  logic [2:0] w_count_nxt;
  logic       w_issue, w_push, w_pop, w_accept, w_finish, w_last_issue;

  // A read is only issued if the FIFO is guaranteed room when its data returns.
  assign w_inflight   = {2'b00, r_vld_p0} + {2'b00, r_vld_p1};
  assign w_issue      = (r_state == S_ISSUE) && ((r_count + w_inflight) < 3'd4);
  assign w_last_issue = (r_remaining == (ADDR_WIDTH+1)'(1));
  assign w_push       = r_vld_p1;
  assign w_pop        = out_valid & out_ready;
  assign w_count_nxt  = r_count + {2'b00, w_push} - {2'b00, w_pop};
  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_finish     = (r_state == S_DRAIN) && !r_vld_p0 && !r_vld_p1 &&
                        (w_count_nxt == 3'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length != '0) w_state_nxt = S_ISSUE;
          else              w_done_nxt  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_issue && w_last_issue) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_finish) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_remaining <= '0;
      r_next_addr <= '0;
      r_read_addr <= '0;
      r_vld_p0    <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_count     <= 3'd0;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_accept && (length != '0)) begin
        r_remaining <= length;
        r_next_addr <= base_addr;
      end
      // Stage p0: address presented to the RAM
      if (w_issue) begin
        r_read_addr <= r_next_addr;
        r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
      end
      r_vld_p0 <= w_issue;
      // Stage p1: RAM q valid, pushed into the FIFO on the following edge
      r_vld_p1 <= r_vld_p0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= q;
  end

`ifdef RAM_READER_LAST_EN
  logic r_last_p0, r_last_p1;
  logic r_last_mem [FIFO_DEPTH];

  always_ff @(posedge clock) begin
    if (w_issue) r_last_p0 <= w_last_issue;
    r_last_p1 <= r_last_p0;
    if (w_push) r_last_mem[r_wr_ptr] <= r_last_p1;
  end

  assign out_last = out_valid & r_last_mem[r_rd_ptr];
`endif

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign read_addr = r_read_addr;
  assign out_valid = (r_count != 3'd0);
  assign out_data  = r_mem[r_rd_ptr];

endmodule
